down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Loadable down-counter/timer with selectable decrement step. It is the counterpart of the team's up-counter and uses the same control interface (load, count_en, 2-bit step select c, data_in).
- Adds three things the up-counter lacks: underflow (borrow) signalling, one-shot expiry, and auto-reload.
- Used as a programmable interval timer next to the up-counter in lab datapaths.

Parameters:
- WIDTH, 4, bit width of count, data_in and the internal reload register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  load data_in into count and reload register; arms one-shot mode.
- count_en  input  1  enables a decrement step this cycle.
- c  input  2  step select: 00 = step 3, 01 = step 1, 10 = step 2, 11 = hold (step 0).
- data_in  input  WIDTH  load value.
- auto_reload  input  1  armed mode only: 1 = reload on underflow, 0 = expire.
- count  output  WIDTH  registered counter value.
- borrow  output  1  registered 1-cycle pulse; high in the cycle after an underflow event.
- expired  output  1  registered level; high while in EXPIRED state.
- zero  output  1  combinational, count == 0.

Behaviour:
- All state updates on posedge clk. Priority: reset > load > count step.
- reset=1: count=0, reload_reg=0, borrow=0, expired=0, state=FREE. A reset in any state, including mid-count, takes effect at the next edge.
- load=1 (no reset), in any state and regardless of count_en/c:
  - count<=data_in, reload_reg<=data_in, borrow<=0, expired<=0, state<=ARMED.
- Effective step S = 3/1/2/0 for c = 00/01/10/11.
- No step when count_en=0 or S=0: count holds, borrow<=0.
- Step event = count_en=1 and S!=0 and no load.
- Underflow = step event with count < S. count == S gives count=0 with no borrow.
- FREE state (after reset):
  - Step event: count <= (count - S) mod 2^WIDTH.
  - borrow<=1 if underflow, else 0. State stays FREE.
- ARMED state:
  - Step event without underflow: count<=count-S, borrow<=0.
  - Underflow with auto_reload=1: count<=reload_reg, borrow<=1, state stays ARMED. Any remainder is discarded.
  - Underflow with auto_reload=0: count<=0, borrow<=1, expired<=1, state<=EXPIRED.
- EXPIRED state:
  - count held at 0, count_en and c ignored, borrow<=0 after the expiry pulse, expired stays 1.
  - Leaves only via load (to ARMED) or reset (to FREE).
- auto_reload is sampled at the underflow edge only; changing it mid-count has no other effect.
- Latency: count, borrow and expired reflect inputs one edge after sampling. zero follows count combinationally.
- Arithmetic is unsigned, WIDTH bits. The comparison count < S uses a zero-extended S. No X propagation: every register has a reset value.

Test Plan:
- Reset, then FREE with c=01, en=1 from 0 -> count 15,14,13. borrow=1 only in the cycle count=15. zero=1 only at start.
- FREE with c=00 from 0 -> count 13,10,7,4,1,14. borrow high in the cycles showing 13 and 14, low otherwise.
- load=1, data_in=9, auto_reload=0, then c=00 -> count 9,6,3,0, then 0 with borrow pulse and expired=1. Further en cycles with c=01 keep count 0, borrow 0, expired 1.
- load data_in=5, auto_reload=1, c=10 -> 5,3,1, then 5 (borrow=1), then 3,1,5... Expired stays 0 throughout.
- c=11 with en=1 for 2 cycles -> count unchanged, borrow 0. Same cycle load=1, data_in=12, en=1, c=00 -> count 12 (load wins), then 9.
- In ARMED at count=6, assert reset for one cycle together with load=1 -> count 0, expired 0, borrow 0, state FREE. Next c=01 step -> 15 with borrow.

Source files
------------

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable down-counter / interval timer with a selectable decrement step.
// It uses the same control interface as the up-counter: load, count_en, a
// 2-bit step select c and data_in. It adds three things:
//   - underflow (borrow) signalling,
//   - one-shot expiry,
//   - auto-reload from a reload register captured at load time.
//
// Operating modes (dbg_state encoding: 0 = FREE, 1 = ARMED, 2 = EXPIRED):
//   FREE    : entered by reset. Wraps modulo 2^WIDTH on underflow.
//   ARMED   : entered by load. On underflow it either reloads (auto_reload=1)
//             or expires (auto_reload=0).
//   EXPIRED : count is held at 0 and expired is high. Only load or reset
//             leave this state.
//
// Update priority on every rising edge: reset > load > count step.
//
// Step select c: 00 -> 3, 01 -> 1, 10 -> 2, 11 -> 0 (hold).
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   load        in   load data_in into count and reload register, arm one-shot
//   count_en    in   enable one decrement step this cycle
//   c           in   step select (see above)
//   data_in     in   WIDTH-bit load value
//   auto_reload in   ARMED only: 1 = reload on underflow, 0 = expire
//   count       out  registered counter value
//   borrow      out  registered one-cycle pulse after an underflow
//   expired     out  registered level, high while EXPIRED
//   zero        out  combinational, count == 0
//   dbg_state   out  current mode, for observation only
// -----------------------------------------------------------------------------
module down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             count_en,
   input  logic [1:0]       c,
   input  logic [WIDTH-1:0] data_in,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             borrow,
   output logic             expired,
   output logic             zero,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_FREE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   // The underflow compare must see the full step value (up to 3) even when
   // WIDTH is 1, so it runs at a width of at least 2 bits plus one spare bit.
   localparam int EW = (WIDTH > 2) ? WIDTH : 2;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             borrow_q, borrow_d;
   logic             expired_q, expired_d;

   logic [EW:0]      step_w;     // zero-extended step size
   logic [EW:0]      count_w;    // zero-extended count for the compare
   logic [WIDTH-1:0] diff;       // count - step, modulo 2^WIDTH
   logic             step_event;
   logic             underflow;

   // ------------------------------------------------------------------------
   // Step decode and arithmetic
   // ------------------------------------------------------------------------
   always_comb begin
      step_w = '0;
      case (c)
         2'b00:   step_w = {{(EW-1){1'b0}}, 2'b11};
         2'b01:   step_w = {{(EW-1){1'b0}}, 2'b01};
         2'b10:   step_w = {{(EW-1){1'b0}}, 2'b10};
         default: step_w = '0;
      endcase
   end

   assign count_w    = {{(EW+1-WIDTH){1'b0}}, count_q};
   // Subtracting the step truncated to WIDTH bits gives the same result
   // modulo 2^WIDTH as subtracting the full step.
   assign diff       = count_q - step_w[WIDTH-1:0];
   assign step_event = count_en && (step_w != '0);
   // Landing exactly on zero (count == step) is not an underflow.
   assign underflow  = step_event && (count_w < step_w);

   // ------------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      borrow_d  = 1'b0;          // borrow is a single-cycle pulse
      expired_d = expired_q;

      if (load) begin
         // Load wins over any step requested in the same cycle.
         count_d   = data_in;
         reload_d  = data_in;
         expired_d = 1'b0;
         state_d   = ST_ARMED;
      end else begin
         case (state_q)
            ST_FREE: begin
               if (step_event) begin
                  count_d  = diff;
                  borrow_d = underflow;
               end
            end

            ST_ARMED: begin
               if (step_event) begin
                  if (underflow) begin
                     borrow_d = 1'b1;
                     if (auto_reload) begin
                        // The remainder past zero is discarded.
                        count_d = reload_q;
                     end else begin
                        count_d   = '0;
                        expired_d = 1'b1;
                        state_d   = ST_EXPIRED;
                     end
                  end else begin
                     count_d = diff;
                  end
               end
            end

            ST_EXPIRED: begin
               // count_en and c are ignored until a load or reset.
               count_d   = '0;
               expired_d = 1'b1;
            end

            default: begin
               // Unreachable encoding: fall back to a clean FREE state.
               state_d   = ST_FREE;
               count_d   = '0;
               expired_d = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FREE;
         count_q   <= '0;
         reload_q  <= '0;
         borrow_q  <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         borrow_q  <= borrow_d;
         expired_q <= expired_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign count     = count_q;
   assign borrow    = borrow_q;
   assign expired   = expired_q;
   assign zero      = (count_q == '0);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the timer (plain integer arithmetic on mode, count and reload value) is
// advanced on every clock edge and gives the expected outputs for the random
// phase; directed scenarios carry their own expected-value tables.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_down_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  localparam int M_FREE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_EXP   = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         load;
  logic         count_en;
  logic [1:0]   c;
  logic [W-1:0] data_in;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         borrow;
  logic         expired;
  logic         zero;
  logic [1:0]   dbg_state;

  down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .count_en    (count_en),
    .c           (c),
    .data_in     (data_in),
    .auto_reload (auto_reload),
    .count       (count),
    .borrow      (borrow),
    .expired     (expired),
    .zero        (zero),
    .dbg_state   (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_mode    = M_FREE;
  int m_count   = 0;
  int m_reload  = 0;
  int m_borrow  = 0;
  int m_expired = 0;

  function automatic int step_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3;
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one edge using the inputs present at that edge.
  task automatic model_update();
    int s;
    s = step_of(c);
    if (reset) begin
      m_mode = M_FREE; m_count = 0; m_reload = 0; m_borrow = 0; m_expired = 0;
    end else if (load) begin
      m_mode = M_ARMED; m_count = int'(data_in); m_reload = int'(data_in);
      m_borrow = 0; m_expired = 0;
    end else if (m_mode == M_EXP) begin
      m_count = 0; m_borrow = 0;
    end else if (!count_en || s == 0) begin
      m_borrow = 0;
    end else if (m_count < s) begin
      m_borrow = 1;
      if (m_mode == M_FREE) begin
        m_count = (m_count + MOD - s) % MOD;
      end else if (auto_reload) begin
        m_count = m_reload;
      end else begin
        m_count = 0; m_expired = 1; m_mode = M_EXP;
      end
    end else begin
      m_count  = m_count - s;
      m_borrow = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic l, input logic en,
                       input logic [1:0] sel, input int d, input logic ar);
    reset       = r;
    load        = l;
    count_en    = en;
    c           = sel;
    data_in     = W'(d);
    auto_reload = ar;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1, 0, 0, 2'b01, 0, 0);
    tick();
    tick();
    checks++;
    if (count !== 4'd0 || borrow !== 1'b0 || expired !== 1'b0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL reset: count=%0d borrow=%b expired=%b zero=%b, want 0 0 0 1",
               count, borrow, expired, zero);
    end
  endtask

  task automatic test_free_step1();
    int exp_cnt [3] = '{15, 14, 13};
    int exp_bor [3] = '{1, 0, 0};
    drive(0, 0, 1, 2'b01, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== W'(exp_cnt[i]) || borrow !== 1'(exp_bor[i]) ||
          expired !== 1'b0 || zero !== 1'b0) begin
        failures++;
        $display("FAIL free_step1[%0d]: count=%0d borrow=%b expired=%b zero=%b, want %0d %0d 0 0",
                 i, count, borrow, expired, zero, exp_cnt[i], exp_bor[i]);
      end
    end
  endtask

  task automatic test_free_step3();
    int exp_cnt [6] = '{13, 10, 7, 4, 1, 14};
    int exp_bor [6] = '{1, 0, 0, 0, 0, 1};
    drive(1, 0, 0, 2'b00, 0, 0);
    tick();
    drive(0, 0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (count !== W'(exp_cnt[i]) || borrow !== 1'(exp_bor[i]) || expired !== 1'b0) begin
        failures++;
        $display("FAIL free_step3[%0d]: count=%0d borrow=%b expired=%b, want %0d %0d 0",
                 i, count, borrow, expired, exp_cnt[i], exp_bor[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_cnt [7] = '{6, 3, 0, 0, 0, 0, 0};
    int exp_bor [7] = '{0, 0, 0, 1, 0, 0, 0};
    int exp_exp [7] = '{0, 0, 0, 1, 1, 1, 1};
    drive(0, 1, 0, 2'b00, 9, 0);
    tick();
    checks++;
    if (count !== 4'd9 || borrow !== 1'b0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_load: count=%0d borrow=%b expired=%b, want 9 0 0",
               count, borrow, expired);
    end
    drive(0, 0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) drive(0, 0, 1, 2'b01, 0, 0);
      tick();
      checks++;
      if (count !== W'(exp_cnt[i]) || borrow !== 1'(exp_bor[i]) ||
          expired !== 1'(exp_exp[i]) || zero !== (exp_cnt[i] == 0)) begin
        failures++;
        $display("FAIL oneshot[%0d]: count=%0d borrow=%b expired=%b zero=%b, want %0d %0d %0d",
                 i, count, borrow, expired, zero, exp_cnt[i], exp_bor[i], exp_exp[i]);
      end
    end
  endtask

  task automatic test_autoreload();
    int exp_cnt [7] = '{5, 3, 1, 5, 3, 1, 5};
    int exp_bor [7] = '{0, 0, 0, 1, 0, 0, 1};
    drive(0, 1, 1, 2'b10, 5, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) drive(0, 0, 1, 2'b10, 0, 1);
      checks++;
      if (count !== W'(exp_cnt[i]) || borrow !== 1'(exp_bor[i]) || expired !== 1'b0) begin
        failures++;
        $display("FAIL autoreload[%0d]: count=%0d borrow=%b expired=%b, want %0d %0d 0",
                 i, count, borrow, expired, exp_cnt[i], exp_bor[i]);
      end
    end
  endtask

  task automatic test_hold_and_load_priority();
    drive(0, 0, 1, 2'b11, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 4'd5 || borrow !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: count=%0d borrow=%b, want 5 0", i, count, borrow);
      end
    end
    drive(0, 1, 1, 2'b00, 12, 1);
    tick();
    checks++;
    if (count !== 4'd12 || borrow !== 1'b0 || expired !== 1'b0) begin
      failures++;
      $display("FAIL load_priority: count=%0d borrow=%b expired=%b, want 12 0 0",
               count, borrow, expired);
    end
    drive(0, 0, 1, 2'b00, 0, 1);
    tick();
    checks++;
    if (count !== 4'd9 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL after_load_step: count=%0d borrow=%b, want 9 0", count, borrow);
    end
  endtask

  task automatic test_reset_mid_count();
    drive(0, 0, 1, 2'b00, 0, 1);
    tick();
    checks++;
    if (count !== 4'd6) begin
      failures++;
      $display("FAIL armed_at_6: count=%0d, want 6", count);
    end
    drive(1, 1, 1, 2'b00, 10, 1);
    tick();
    checks++;
    if (count !== 4'd0 || borrow !== 1'b0 || expired !== 1'b0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_over_load: count=%0d borrow=%b expired=%b zero=%b, want 0 0 0 1",
               count, borrow, expired, zero);
    end
    // Back in FREE, an underflow wraps instead of reloading from the old value.
    drive(0, 0, 1, 2'b01, 0, 1);
    tick();
    checks++;
    if (count !== 4'd15 || borrow !== 1'b1 || expired !== 1'b0) begin
      failures++;
      $display("FAIL free_after_reset: count=%0d borrow=%b expired=%b, want 15 1 0",
               count, borrow, expired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)));
      tick();
      checks++;
      if (count !== W'(m_count) || borrow !== 1'(m_borrow) ||
          expired !== 1'(m_expired) || zero !== (m_count == 0)) begin
        failures++;
        $display("FAIL random[%0d]: count=%0d borrow=%b expired=%b zero=%b, want %0d %0d %0d %0d",
                 i, count, borrow, expired, zero, m_count, m_borrow, m_expired,
                 (m_count == 0));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    drive(1, 0, 0, 2'b00, 0, 0);
    test_reset();
    test_free_step1();
    test_free_step3();
    test_oneshot();
    test_autoreload();
    test_hold_and_load_priority();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
